relu_wb_seq: RTL and testbench

Sequencer for the ReLU memory write-back instruction of the HWPE coprocessor. On a start pulse from the instruction decoder it walks the PE array in order. For each PE it reads one accumulator register, applies ReLU, and issues one memory write with a valid/ready handshake. It raises a one-cycle done pulse when the final PE has been written; this drives the delayed EAI response for non-immediate instructions.

---
 rtl/relu_wb_seq.sv | 176 +++++++++++++++++
 tb/tb_relu_wb_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_wb_seq.sv
// ---------------------------------------------------------------------------
// relu_wb_seq
//
// Sequencer for the ReLU memory write-back instruction of the HWPE
// coprocessor. After an accepted start pulse it visits PE0..PE(N_PE-1) in
// order. For each PE it:
//   1. strobes one accumulator register read (READ),
//   2. captures the read data one cycle later and applies ReLU (WAIT),
//   3. holds one memory write request until the valid/ready handshake
//      completes (WRITE).
// After the last PE has been written it emits a one-cycle done pulse (DONE).
// The done pulse drives the delayed EAI response of non-immediate
// instructions.
//
// Optional build macro:
//   RELU_WB_SAT_EN - when defined, post-ReLU values above 255 are clamped
//                    to 255, so the written data is an 8-bit activation.
//                    When undefined, positive values pass unchanged.
//
// Ports:
//   clk           - clock, all logic on the rising edge
//   rst           - synchronous active-high reset
//   start         - one-cycle start pulse from the decoder
//   abort         - instruction reset; cancels any operation
//   acc_id        - accumulator register to dump, sampled on accepted start
//   base_addr     - byte address of the PE0 result, sampled on accepted start
//   acc_ren       - accumulator read strobe
//   acc_r_acc_id  - accumulator index for the read
//   acc_r_pe_id   - PE index for the read
//   acc_rd        - accumulator read data, valid one cycle after acc_ren
//   mem_req_valid - memory write request valid
//   mem_req_ready - memory write request accepted
//   mem_addr      - write byte address
//   mem_wdata     - write data (post-ReLU)
//   busy          - high whenever the sequencer is not idle
//   done          - one-cycle completion pulse
//   err           - one-cycle pulse when start arrives while busy
// ---------------------------------------------------------------------------
module relu_wb_seq #(
    parameter int N_PE        = 16,
    parameter int PE_ID_W     = 4,
    parameter int ACC_ID_W    = 3,
    parameter int DATA_W      = 32,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ACC_ID_W-1:0] acc_id,
    input  logic [31:0]         base_addr,
    output logic                acc_ren,
    output logic [ACC_ID_W-1:0] acc_r_acc_id,
    output logic [PE_ID_W-1:0]  acc_r_pe_id,
    input  logic [DATA_W-1:0]   acc_rd,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [PE_ID_W-1:0] LAST_PE = PE_ID_W'(N_PE - 1);

    state_t                state_r;
    logic [PE_ID_W-1:0]    pe_cnt_r;
    logic [ACC_ID_W-1:0]   acc_id_q_r;
    logic [31:0]           base_q_r;
    logic [DATA_W-1:0]     data_q_r;
    logic [31:0]           addr_r;
    logic                  err_r;

    // ReLU on a two's-complement accumulator value, with optional 8-bit clamp.
    function automatic logic [DATA_W-1:0] relu_fn(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v[DATA_W-1]) begin
            r = {DATA_W{1'b0}};
        end else begin
            r = v;
        end
`ifdef RELU_WB_SAT_EN
        if (r > DATA_W'(255)) begin
            r = DATA_W'(255);
        end else begin
            r = r;
        end
`endif
        return r;
    endfunction

    // Main sequencer: state, PE counter, latched operands, write data/address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pe_cnt_r   <= {PE_ID_W{1'b0}};
            acc_id_q_r <= {ACC_ID_W{1'b0}};
            base_q_r   <= 32'h0000_0000;
            data_q_r   <= {DATA_W{1'b0}};
            addr_r     <= 32'h0000_0000;
            err_r      <= 1'b0;
        end else begin
            // A start that arrives outside IDLE (DONE included) is dropped and
            // flagged; abort wins over start so a simultaneous pair is silent.
            err_r <= start && !abort && (state_r != S_IDLE);

            if (abort) begin
                state_r <= S_IDLE;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            acc_id_q_r <= acc_id;
                            base_q_r   <= base_addr;
                            pe_cnt_r   <= {PE_ID_W{1'b0}};
                            state_r    <= S_READ;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_READ: begin
                        state_r <= S_WAIT;
                    end
                    S_WAIT: begin
                        // acc_rd is valid in this cycle only; the address is
                        // prepared here so the request is fully registered.
                        data_q_r <= relu_fn(acc_rd);
                        addr_r   <= base_q_r + (32'(pe_cnt_r) * 32'(ADDR_STRIDE));
                        state_r  <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (mem_req_ready) begin
                            if (pe_cnt_r == LAST_PE) begin
                                state_r <= S_DONE;
                            end else begin
                                pe_cnt_r <= pe_cnt_r + PE_ID_W'(1);
                                state_r  <= S_READ;
                            end
                        end else begin
                            state_r <= S_WRITE;
                        end
                    end
                    S_DONE: begin
                        state_r <= S_IDLE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Strobes are pure decodes of the registered state, so no input reaches
    // an output without passing through a flop.
    assign acc_ren       = (state_r == S_READ);
    assign mem_req_valid = (state_r == S_WRITE);
    assign done          = (state_r == S_DONE);
    assign busy          = (state_r != S_IDLE);

    assign acc_r_pe_id   = pe_cnt_r;
    assign acc_r_acc_id  = acc_id_q_r;
    assign mem_addr      = addr_r;
    assign mem_wdata     = data_q_r;
    assign err           = err_r;

endmodule

// File: tb/tb_relu_wb_seq.sv
module tb_relu_wb_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  acc_id;
    logic [31:0] base_addr;
    logic        acc_ren;
    logic [2:0]  acc_r_acc_id;
    logic [3:0]  acc_r_pe_id;
    logic [31:0] acc_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int s_cyc = 0;

    logic [31:0] acc_mem [0:15][0:7];

    int          wr_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          ren_cyc_q[$];
    logic [3:0]  ren_pe_q[$];
    logic [2:0]  ren_acc_q[$];
    int          done_q[$];
    int          err_q[$];
    logic [31:0] stall_addr_q[$];
    logic [31:0] stall_data_q[$];

    relu_wb_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .acc_id        (acc_id),
        .base_addr     (base_addr),
        .acc_ren       (acc_ren),
        .acc_r_acc_id  (acc_r_acc_id),
        .acc_r_pe_id   (acc_r_pe_id),
        .acc_rd        (acc_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator file model: data valid exactly one cycle after acc_ren.
    always @(posedge clk) begin
        if (acc_ren) acc_rd <= acc_mem[acc_r_pe_id][acc_r_acc_id];
        else         acc_rd <= 32'hDEAD_BEEF;
    end

    // Event logger, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_req_valid && !mem_req_ready) begin
            stall_addr_q.push_back(mem_addr);
            stall_data_q.push_back(mem_wdata);
        end
        if (acc_ren) begin
            ren_cyc_q.push_back(cyc);
            ren_pe_q.push_back(acc_r_pe_id);
            ren_acc_q.push_back(acc_r_acc_id);
        end
        if (done) done_q.push_back(cyc);
        if (err)  err_q.push_back(cyc);
    end

    task automatic fill_mem();
        for (int p = 0; p < 16; p++)
            for (int a = 0; a < 8; a++)
                acc_mem[p][a] = (a == 3) ? 32'(p * 10) : 32'(a * 16 + p);
    endtask

    task automatic do_start(input logic [2:0] id, input logic [31:0] base);
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        ren_cyc_q.delete(); ren_pe_q.delete(); ren_acc_q.delete();
        done_q.delete(); err_q.delete();
        stall_addr_q.delete(); stall_data_q.delete();
        @(posedge clk); #1;
        s_cyc = cyc;
        start = 1'b1; acc_id = id; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives ready/start/abort per cycle until the DUT goes idle or budget expires.
    task automatic run_op(input int budget, input int stall_from, input int stall_len,
                          input int start_at, input int abort_at, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (1'b1) begin
            mem_req_ready = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);
            start = (cyc == start_at);
            abort = (cyc == abort_at);
            if (cyc == start_at) begin
                acc_id = 3'd5; base_addr = 32'h0000_9000;
            end
            @(posedge clk); #1;
            n++;
            if (!busy) break;
            if (n >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0; abort = 1'b0; mem_req_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({acc_ren, acc_r_acc_id, acc_r_pe_id, mem_req_valid, busy, done, err} !== 13'd0) begin
            $display("FAIL reset_ctrl got=%b exp=0", {acc_ren, acc_r_acc_id, acc_r_pe_id, mem_req_valid, busy, done, err});
        end else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'd0) $display("FAIL reset_addr got=%h exp=0", mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (mem_wdata !== 32'd0) $display("FAIL reset_wdata got=%h exp=0", mem_wdata);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        bit to;
        fill_mem();
        do_start(3'd3, 32'h0000_1000);
        run_op(200, -1, 0, -1, -1, to);
        total_cnt++;
        if (to !== 1'b0) $display("FAIL basic_timeout got=%b exp=0", to); else pass_cnt++;
        total_cnt++;
        if (wr_addr_q.size() !== 16) $display("FAIL basic_nwr got=%0d exp=16", wr_addr_q.size()); else pass_cnt++;
        total_cnt++;
        if (ren_cyc_q.size() !== 16) $display("FAIL basic_nren got=%0d exp=16", ren_cyc_q.size()); else pass_cnt++;
        for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== 32'h1000 + 32'(4 * i))
                $display("FAIL basic_addr[%0d] got=%h exp=%h", i, wr_addr_q[i], 32'h1000 + 32'(4 * i));
            else pass_cnt++;
            total_cnt++;
            if (wr_data_q[i] !== 32'(i * 10))
                $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, wr_data_q[i], i * 10);
            else pass_cnt++;
            total_cnt++;
            if (wr_cyc_q[i] !== s_cyc + 3 + 3 * i)
                $display("FAIL basic_wrcyc[%0d] got=%0d exp=%0d", i, wr_cyc_q[i] - s_cyc, 3 + 3 * i);
            else pass_cnt++;
        end
        for (int i = 0; i < 16 && i < ren_cyc_q.size(); i++) begin
            total_cnt++;
            if (ren_cyc_q[i] !== s_cyc + 1 + 3 * i || ren_pe_q[i] !== 4'(i) || ren_acc_q[i] !== 3'd3)
                $display("FAIL basic_ren[%0d] got=cyc%0d pe%0d acc%0d exp=cyc%0d pe%0d acc3",
                         i, ren_cyc_q[i] - s_cyc, ren_pe_q[i], ren_acc_q[i], 1 + 3 * i, i);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_q.size() !== 1 || done_q[0] !== s_cyc + 49)
            $display("FAIL basic_done got=n%0d cyc%0d exp=n1 cyc49", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] - s_cyc : -1);
        else pass_cnt++;
        total_cnt++;
        if (err_q.size() !== 0) $display("FAIL basic_err got=%0d exp=0", err_q.size()); else pass_cnt++;
    endtask

    task automatic test_relu();
        bit to;
        logic [31:0] exp6;
`ifdef RELU_WB_SAT_EN
        exp6 = 32'd255;
`else
        exp6 = 32'h7FFF_FFFF;
`endif
        fill_mem();
        acc_mem[5][3] = 32'hFFFF_FFF6;
        acc_mem[6][3] = 32'h7FFF_FFFF;
        do_start(3'd3, 32'h0000_1000);
        run_op(200, -1, 0, -1, -1, to);
        total_cnt++;
        if (wr_data_q.size() !== 16) $display("FAIL relu_nwr got=%0d exp=16", wr_data_q.size());
        else begin
            pass_cnt++;
            total_cnt++;
            if (wr_data_q[5] !== 32'd0) $display("FAIL relu_neg got=%h exp=0", wr_data_q[5]); else pass_cnt++;
            total_cnt++;
            if (wr_data_q[6] !== exp6) $display("FAIL relu_pos got=%h exp=%h", wr_data_q[6], exp6); else pass_cnt++;
            total_cnt++;
            if (wr_data_q[7] !== 32'd70) $display("FAIL relu_next got=%0d exp=70", wr_data_q[7]); else pass_cnt++;
        end
        fill_mem();
    endtask

    task automatic test_backpressure();
        bit to;
        do_start(3'd3, 32'h0000_1000);
        run_op(200, s_cyc + 9, 5, -1, -1, to);
        total_cnt++;
        if (stall_addr_q.size() !== 5) $display("FAIL bp_nstall got=%0d exp=5", stall_addr_q.size()); else pass_cnt++;
        for (int i = 0; i < stall_addr_q.size(); i++) begin
            total_cnt++;
            if (stall_addr_q[i] !== 32'h1008 || stall_data_q[i] !== 32'd20)
                $display("FAIL bp_stable[%0d] got=%h/%0d exp=1008/20", i, stall_addr_q[i], stall_data_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (wr_cyc_q.size() !== 16 || wr_cyc_q[2] !== s_cyc + 14 || wr_data_q[2] !== 32'd20)
            $display("FAIL bp_pe2 got=n%0d exp=n16 at cyc14 data20", wr_cyc_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() !== 1 || done_q[0] !== s_cyc + 54)
            $display("FAIL bp_done got=n%0d cyc%0d exp=n1 cyc54", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] - s_cyc : -1);
        else pass_cnt++;
    endtask

    task automatic test_busy_start();
        bit to;
        int bad;
        do_start(3'd3, 32'h0000_1000);
        run_op(200, -1, 0, s_cyc + 13, -1, to);
        total_cnt++;
        if (err_q.size() !== 1 || err_q[0] !== s_cyc + 14)
            $display("FAIL busy_err got=n%0d cyc%0d exp=n1 cyc14", err_q.size(),
                     (err_q.size() > 0) ? err_q[0] - s_cyc : -1);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 32'h1000 + 32'(4 * i) || wr_data_q[i] !== 32'(i * 10)) bad++;
        total_cnt++;
        if (wr_addr_q.size() !== 16 || bad != 0)
            $display("FAIL busy_writes got=n%0d bad%0d exp=n16 bad0", wr_addr_q.size(), bad);
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() !== 1) $display("FAIL busy_done got=%0d exp=1", done_q.size()); else pass_cnt++;
    endtask

    task automatic test_abort();
        bit to;
        do_start(3'd3, 32'h0000_1000);
        run_op(200, s_cyc + 24, 10, -1, s_cyc + 24, to);
        total_cnt++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b0 || acc_ren !== 1'b0)
            $display("FAIL abort_drop got=v%b b%b r%b exp=000", mem_req_valid, busy, acc_ren);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== s_cyc + 25) $display("FAIL abort_cyc got=%0d exp=25", cyc - s_cyc); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (done_q.size() !== 0 || wr_addr_q.size() !== 7)
            $display("FAIL abort_nodone got=d%0d w%0d exp=d0 w7", done_q.size(), wr_addr_q.size());
        else pass_cnt++;
        do_start(3'd1, 32'h0000_2000);
        run_op(200, -1, 0, -1, -1, to);
        total_cnt++;
        if (wr_addr_q.size() !== 16 || wr_addr_q[0] !== 32'h2000 || wr_data_q[0] !== 32'h10)
            $display("FAIL abort_restart got=n%0d exp=n16 addr2000 data10", wr_addr_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() !== 1) $display("FAIL abort_redone got=%0d exp=1", done_q.size()); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit to;
        do_start(3'd3, 32'hFFFF_FFF8);
        run_op(200, -1, 0, -1, -1, to);
        total_cnt++;
        if (wr_addr_q.size() !== 16) $display("FAIL wrap_nwr got=%0d exp=16", wr_addr_q.size());
        else begin
            pass_cnt++;
            total_cnt++;
            if (wr_addr_q[1] !== 32'hFFFF_FFFC) $display("FAIL wrap_pe1 got=%h exp=fffffffc", wr_addr_q[1]); else pass_cnt++;
            total_cnt++;
            if (wr_addr_q[2] !== 32'h0000_0000) $display("FAIL wrap_pe2 got=%h exp=00000000", wr_addr_q[2]); else pass_cnt++;
            total_cnt++;
            if (wr_addr_q[15] !== 32'h0000_0034) $display("FAIL wrap_pe15 got=%h exp=00000034", wr_addr_q[15]); else pass_cnt++;
        end
        total_cnt++;
        if (done_q.size() !== 1) $display("FAIL wrap_done got=%0d exp=1", done_q.size()); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; acc_id = 3'd0;
        base_addr = 32'd0; mem_req_ready = 1'b1;
        fill_mem();
        test_reset();
        test_basic();
        test_relu();
        test_backpressure();
        test_busy_start();
        test_abort();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
